// File: rtl/topk_pkg.sv
// Shared types for the 16-input sorter result interface and its top-K drain.
package topk_pkg;

  localparam int TOPK_DW    = 8;
  localparam int TOPK_LEN   = 16;
  localparam int DRAIN_IDXW = 4;

  typedef enum logic [1:0] {
    GRP4     = 2'd0,
    GRP8     = 2'd1,
    GRP16    = 2'd2,
    GRP_RSVD = 2'd3
  } drain_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } drain_state_e;

  typedef struct packed {
    logic       sign_ctrl;
    logic [3:0] channel_4;
    logic [1:0] channel_8;
    logic [0:0] channel_16;
  } ctrl_t;

  typedef struct packed {
    logic [3:0][3:0][TOPK_DW-1:0]  data_4;
    logic [1:0][7:0][TOPK_DW-1:0]  data_8;
    logic [0:0][15:0][TOPK_DW-1:0] data_16;
  } data_o_t;

  typedef struct packed {
    logic [TOPK_LEN-1:0][TOPK_DW-1:0] data;
    logic [3:0]                       gmask;
    drain_mode_e                      mode;
    logic [4:0]                       k;
    logic                             sign;
  } drain_entry_t;

  function automatic logic [4:0] grp_size(input drain_mode_e m);
    case (m)
      GRP4:    return 5'd4;
      GRP8:    return 5'd8;
      GRP16:   return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] keff_of(input drain_entry_t e);
    logic [4:0] g;
    g = grp_size(e.mode);
    return (e.k < g) ? e.k : g;
  endfunction

  function automatic logic [1:0] low_bit(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [1:0] high_bit(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (m[i]) r = 2'(i);
    return r;
  endfunction

  // Lowest set group strictly above cur.
  function automatic logic [1:0] next_bit(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] r;
    r = cur;
    for (int i = 3; i >= 0; i--) if (m[i] && (i > int'(cur))) r = 2'(i);
    return r;
  endfunction

endpackage

// File: rtl/topk_drain_fifo.sv
// Synchronous FIFO of drain entries; one-cycle write-to-read, registered free count.
// Pushes into a full FIFO are ignored even if a pop happens in the same cycle.
module topk_drain_fifo
  import topk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  drain_entry_t           push_dat_i,
  input  logic                   pop_i,
  output drain_entry_t           head_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] free_o
);

  localparam int AW = $clog2(DEPTH);

  drain_entry_t          mem_q [DEPTH];
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]           free_q, free_d;
  logic                  push_ok, pop_ok;

  always_comb begin
    full_o  = (free_q == '0);
    empty_o = (free_q == (AW+1)'(DEPTH));
    push_ok = push_i && !full_o;
    pop_ok  = pop_i && !empty_o;
    wr_d    = wr_q + AW'(push_ok);
    rd_d    = rd_q + AW'(pop_ok);
    free_d  = free_q - (AW+1)'(push_ok) + (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      free_q <= (AW+1)'(DEPTH);
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      free_q <= free_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_q];
  assign free_o     = free_q;

endmodule

// File: rtl/topk_drain_16.sv
// Buffers strobed sorter results and streams the top-K of each valid group, first element two cycles after the strobe.
// out_ready_i low holds the current element; strobes into a full buffer are dropped and set sticky overflow.
module topk_drain_16
  import topk_pkg::*;
#(
  parameter int DATAWIDTH  = TOPK_DW,
  parameter int DATALENGTH = TOPK_LEN,
  parameter int DEPTH      = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  ctrl_t                  ctrl_i,
  input  data_o_t                y_i,
  input  logic [1:0]             mode_i,
  input  logic [4:0]             k_i,
  output logic [DATAWIDTH-1:0]   out_data_o,
  output logic [DRAIN_IDXW-1:0]  out_idx_o,
  output logic                   out_sign_o,
  output logic                   out_last_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [$clog2(DEPTH):0] free_o,
  output logic                   overflow_o
);

  logic [DATALENGTH-1:0][DATAWIDTH-1:0] push_data;
  logic [3:0]    gmask;
  drain_entry_t  push_ent, head_ent, ent_q, ent_d;
  logic          full, empty, pop;
  drain_state_e  state_q, state_d;
  logic [1:0]    grp_q, grp_d;
  logic [4:0]    elem_q, elem_d, keff_cur;
  logic          ovf_q, ovf_d, elem_last, ent_last;

  // The packed result arrays already lay group g at elements [G*g +: G].
  always_comb begin
    push_data = '0;
    gmask     = 4'd0;
    case (drain_mode_e'(mode_i))
      GRP4:    begin push_data = y_i.data_4;  gmask = ctrl_i.channel_4;               end
      GRP8:    begin push_data = y_i.data_8;  gmask = {2'b00, ctrl_i.channel_8};      end
      GRP16:   begin push_data = y_i.data_16; gmask = {3'b000, ctrl_i.channel_16};    end
      default: begin push_data = '0;          gmask = 4'd0;                           end
    endcase
    push_ent       = '0;
    push_ent.data  = push_data;
    push_ent.gmask = gmask;
    push_ent.mode  = drain_mode_e'(mode_i);
    push_ent.k     = k_i;
    push_ent.sign  = ctrl_i.sign_ctrl;
  end

  topk_drain_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (gmask != 4'd0),
    .push_dat_i (push_ent),
    .pop_i      (pop),
    .head_dat_o (head_ent),
    .full_o     (full),
    .empty_o    (empty),
    .free_o     (free_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ent_q   <= '0;
      grp_q   <= 2'd0;
      elem_q  <= 5'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
      grp_q   <= grp_d;
      elem_q  <= elem_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    keff_cur  = keff_of(ent_q);
    elem_last = (elem_q == keff_cur - 5'd1);
    ent_last  = elem_last && (grp_q == high_bit(ent_q.gmask));
    ovf_d     = ovf_q | ((gmask != 4'd0) && full);
    state_d   = state_q;
    ent_d     = ent_q;
    grp_d     = grp_q;
    elem_d    = elem_q;
    pop       = 1'b0;
    // Loading an entry whose keff is zero retires it through IDLE without output.
    if ((state_q == ST_IDLE || (out_ready_i && ent_last)) && !empty) begin
      pop     = 1'b1;
      ent_d   = head_ent;
      grp_d   = low_bit(head_ent.gmask);
      elem_d  = 5'd0;
      state_d = (keff_of(head_ent) == 5'd0) ? ST_IDLE : ST_EMIT;
    end else if (state_q == ST_EMIT && out_ready_i) begin
      if (!elem_last) begin
        elem_d = elem_q + 5'd1;
      end else if (!ent_last) begin
        grp_d  = next_bit(ent_q.gmask, grp_q);
        elem_d = 5'd0;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    out_valid_o = (state_q == ST_EMIT);
    case (ent_q.mode)
      GRP4:    out_idx_o = {grp_q, elem_q[1:0]};
      GRP8:    out_idx_o = {grp_q[0], elem_q[2:0]};
      default: out_idx_o = elem_q[3:0];
    endcase
    out_data_o = ent_q.data[out_idx_o];
    out_sign_o = ent_q.sign;
    out_last_o = out_valid_o && ent_last;
    overflow_o = ovf_q;
  end

endmodule
